// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Logic, arithmetic and shift ops finish in the accept cycle. MUL/MULHU/DIVU/REMU
// run one shift-add or restoring-subtract step per cycle over WIDTH cycles.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] opnd_reg;   // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] hi_reg;     // product high half / partial remainder
  logic [WIDTH-1:0] lo_reg;     // multiplier bits / dividend-then-quotient
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] aluout_reg;
  logic             zero_reg;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] single_result;
  logic             start_multi;
  logic             op_is_mul;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_rem_next, div_q_next;
  logic [WIDTH-1:0] final_result;

  assign shamt = srcb[SHW-1:0];

  // Single-cycle result, computed straight from the inputs at accept time
  always_comb begin
    single_result = '0;
    case (alucontrol)
      OP_ADD:  single_result = srca + srcb;
      OP_SUB:  single_result = srca - srcb;
      OP_SLT:  single_result = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
      OP_SLTU: single_result = {{(WIDTH-1){1'b0}}, srca < srcb};
      OP_XOR:  single_result = srca ^ srcb;
      OP_OR:   single_result = srca | srcb;
      OP_AND:  single_result = srca & srcb;
      OP_SLL:  single_result = srca << shamt;
      OP_SRL:  single_result = srca >> shamt;
      OP_SRA:  single_result = $signed(srca) >>> shamt;
      default: single_result = '0;
    endcase
  end

  // Classify the incoming op and the op currently iterating
  always_comb begin
    start_multi = (alucontrol == OP_MUL) || (alucontrol == OP_MULHU) ||
                  (alucontrol == OP_DIVU) || (alucontrol == OP_REMU);
    op_is_mul   = (op_reg == OP_MUL) || (op_reg == OP_MULHU);
  end

  // One iteration step for both algorithms; the final step's value is the result
  always_comb begin
    // Shift-add multiply: add multiplicand when the current multiplier bit is set,
    // then shift the whole {carry, hi, lo} right by one.
    mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    // Restoring divide: shift next dividend bit into the remainder and subtract if it fits.
    // A zero divisor always "fits", which yields all-ones quotient and remainder = dividend.
    div_shift    = {hi_reg, lo_reg[WIDTH-1]};
    div_ge       = div_shift >= {1'b0, opnd_reg};
    div_diff     = div_shift[WIDTH-1:0] - opnd_reg;
    div_rem_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_q_next   = {lo_reg[WIDTH-2:0], div_ge};
    final_result = '0;
    case (op_reg)
      OP_MUL:   final_result = mul_lo_next;
      OP_MULHU: final_result = mul_hi_next;
      OP_DIVU:  final_result = div_q_next;
      default:  final_result = div_rem_next;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = start_multi ? BUSY : DONE;
      BUSY:    if (cnt_reg == CW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      aluout_reg <= '0;
      zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg <= alucontrol;
            if (start_multi) begin
              cnt_reg <= CW'(WIDTH);
              hi_reg  <= '0;
              if ((alucontrol == OP_MUL) || (alucontrol == OP_MULHU)) begin
                opnd_reg <= srca;
                lo_reg   <= srcb;
              end else begin
                opnd_reg <= srcb;
                lo_reg   <= srca;
              end
            end else begin
              aluout_reg <= single_result;
              zero_reg   <= (single_result == '0);
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (op_is_mul) begin
            hi_reg <= mul_hi_next;
            lo_reg <= mul_lo_next;
          end else begin
            hi_reg <= div_rem_next;
            lo_reg <= div_q_next;
          end
          if (cnt_reg == CW'(1)) begin
            aluout_reg <= final_result;
            zero_reg   <= (final_result == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == BUSY);
  assign out_valid = (state_reg == DONE);
  assign aluout    = aluout_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 with hand-computed expected values.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] srca, srcb;
  logic [3:0]  alucontrol;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aluout;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .aluout     (aluout),
    .zero       (zero),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for the result, check it, then consume it.
  // Latency counts the accept cycle as cycle 1.
  task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_ready_before"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; alucontrol = ctl; srca = a; srcb = b;
    @(posedge clk); #1;
    in_valid = 1'b0; srca = $urandom; srcb = $urandom; alucontrol = 4'($urandom_range(0, 15));
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (exp_lat > 1) begin
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_in_ready_busy"}, {31'b0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_aluout"}, aluout, exp);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp == 32'd0)});
    check({tag, "_ready_in_done"}, {31'b0, in_ready}, 32'd0);
    $display("op %s ctl=%b a=0x%08h b=0x%08h -> 0x%08h zero=%0b lat=%0d",
             tag, ctl, a, b, aluout, zero, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_after"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    srca = '0; srcb = '0; alucontrol = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_aluout", aluout, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle ops
    run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
    run_op("sub_zero", 4'b1000, 32'd5, 32'd5, 32'd0, 1);
    run_op("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("sra", 4'b1101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1);
    run_op("sll", 4'b0001, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1);
    run_op("srl", 4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1);
    run_op("xor", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    run_op("or", 4'b0110, 32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0, 1);
    run_op("and", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    run_op("op1001", 4'b1001, 32'd5, 32'd6, 32'd0, 1);

    // Iterative ops
    run_op("mul_ff", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    run_op("mulhu_ff", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mul_small", 4'b1010, 32'd7, 32'd6, 32'd42, 33);
    run_op("divu", 4'b1100, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 4'b1110, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_big", 4'b1100, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33);
    run_op("divu_by0", 4'b1100, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 33);
    run_op("remu_by0", 4'b1110, 32'd9, 32'd0, 32'd9, 33);

    // DONE held for 10 cycles with in_valid asserted: result stable, nothing accepted
    @(negedge clk);
    in_valid = 1'b1; alucontrol = 4'b0000; srca = 32'd3; srcb = 32'd4;
    @(posedge clk); #1;
    srca = 32'd100; srcb = 32'd200; alucontrol = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_aluout", aluout, 32'd7);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    $display("op hold ctl=0000 a=0x00000003 b=0x00000004 -> 0x%08h held 10 cycles", aluout);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release_ready", {31'b0, in_ready}, 32'd1);
    check("hold_release_valid", {31'b0, out_valid}, 32'd0);
    run_op("after_hold", 4'b0000, 32'd1, 32'd2, 32'd3, 1);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; alucontrol = 4'b1010; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("midmul_busy", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_aluout", aluout, 32'd0);
    check("arst_zero", {31'b0, zero}, 32'd0);
    $display("op reset_mid_mul ctl=1010 aborted at cycle 10");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("arst_no_result", 32'(seen), 32'd0);
    run_op("add_after_rst", 4'b0000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
